asteroid_scheduler: RTL and testbench

- Sequences the asteroid sprite slots in the game top level: decides when each asteroid slot is launched, at which x position, and at what speed level.
- Replaces free-running per-slot enables with a single spawn scheduler driven by a per-frame tick, the rng output and the collision halt.
- Outputs feed the asteroid_move instances (`asteroid_on`, start x, speed) and the pixel layer logic (slot active).

---
 rtl/asteroid_scheduler.sv | 170 +++++++++++++++++
 tb/tb_asteroid_scheduler.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/asteroid_scheduler.sv
// asteroid_scheduler
//   Single spawn scheduler for the asteroid sprite slots. A frame-driven gap
//   timer counts down to the next launch. The lowest free slot is then picked
//   and launched at a random x position. A per-level frame counter shortens
//   the gap and raises the speed level. The collision halt freezes everything.
//
//   Optional build macro: SCHED_PERF_EN adds the spawn/defer performance counters.
//
// Ports
//   i_clk          pixel clock
//   i_reset        asynchronous active-high full restart
//   i_halt         collision freeze
//   i_frame_tick   one-cycle pulse per video frame
//   i_random       rng value, sampled while picking a slot
//   i_slot_done    per-slot pulse: asteroid has left the screen
//   o_slot_active  slot currently launched
//   o_spawn        one-hot, one-cycle launch pulse
//   o_spawn_x      start x for the slot pulsed in o_spawn
//   o_speed_level  difficulty level 0..7
//   o_spawn_count  (SCHED_PERF_EN) saturating count of launches
//   o_defer_count  (SCHED_PERF_EN) saturating count of cycles stalled with no free slot
//
// state  | meaning
// WAIT   | gap timer running, decremented once per frame tick
// PICK   | choose lowest free slot and latch x; retry while all slots busy
// SPAWN  | launch pulse for the picked slot, gap timer reloaded
// HALTED | collision freeze; leaves to WAIT once halt drops

module asteroid_scheduler #(
    parameter int NUM_SLOTS    = 3,
    parameter int INIT_GAP     = 90,
    parameter int MIN_GAP      = 20,
    parameter int GAP_STEP     = 5,
    parameter int LEVEL_FRAMES = 600,
    parameter int X_STEP       = 20
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_halt,
    input  logic                 i_frame_tick,
    input  logic [4:0]           i_random,
    input  logic [NUM_SLOTS-1:0] i_slot_done,
    output logic [NUM_SLOTS-1:0] o_slot_active,
    output logic [NUM_SLOTS-1:0] o_spawn,
    output logic [9:0]           o_spawn_x,
    output logic [2:0]           o_speed_level
`ifdef SCHED_PERF_EN
    ,
    output logic [15:0]          o_spawn_count,
    output logic [15:0]          o_defer_count
`endif
);

    localparam logic [1:0] S_WAIT   = 2'd0;
    localparam logic [1:0] S_PICK   = 2'd1;
    localparam logic [1:0] S_SPAWN  = 2'd2;
    localparam logic [1:0] S_HALTED = 2'd3;

    localparam logic [15:0] INIT_GAP_W   = 16'(INIT_GAP);
    localparam logic [15:0] MIN_GAP_W    = 16'(MIN_GAP);
    localparam logic [15:0] GAP_STEP_W   = 16'(GAP_STEP);
    localparam logic [15:0] LEVEL_LAST_W = 16'(LEVEL_FRAMES - 1);
    localparam logic [9:0]  X_STEP_W     = 10'(X_STEP);

    logic [1:0]           r_state;
    logic [15:0]          r_gap_cnt;
    logic [15:0]          r_cur_gap;
    logic [15:0]          r_level_cnt;
    logic [2:0]           r_speed_level;
    logic [NUM_SLOTS-1:0] r_slot_active;
    logic [NUM_SLOTS-1:0] r_pick_oh;
    logic [9:0]           r_spawn_x;

    logic [NUM_SLOTS-1:0] w_free;
    logic [NUM_SLOTS-1:0] w_free_oh;
    logic                 w_any_free;
    logic [9:0]           w_spawn_x;
    logic                 w_level_wrap;
    logic [15:0]          w_next_gap;
    logic                 w_run;

    assign w_free     = ~r_slot_active;
    // x & -x isolates the lowest set bit: lowest-index free slot
    assign w_free_oh  = w_free & (~w_free + NUM_SLOTS'(1));
    assign w_any_free = |w_free;
    // 10-bit product truncates the random*step result as intended
    assign w_spawn_x  = {5'd0, i_random} * X_STEP_W;
    assign w_level_wrap = i_frame_tick && (r_level_cnt == LEVEL_LAST_W);
    assign w_next_gap = (r_cur_gap >= MIN_GAP_W + GAP_STEP_W) ? (r_cur_gap - GAP_STEP_W)
                                                               : MIN_GAP_W;
    // normal operation: not frozen by halt and not in the halt recovery cycle
    assign w_run = !i_halt && (r_state != S_HALTED);

    // halt gates the pulse combinationally so a collision never launches a slot
    assign o_spawn       = (r_state == S_SPAWN && !i_halt) ? r_pick_oh : '0;
    assign o_slot_active = r_slot_active;
    assign o_spawn_x     = r_spawn_x;
    assign o_speed_level = r_speed_level;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state       <= S_WAIT;
            r_gap_cnt     <= INIT_GAP_W;
            r_cur_gap     <= INIT_GAP_W;
            r_level_cnt   <= '0;
            r_speed_level <= '0;
            r_slot_active <= '0;
            r_pick_oh     <= '0;
            r_spawn_x     <= '0;
        end else if (i_halt) begin
            r_state <= S_HALTED;
        end else if (r_state == S_HALTED) begin
            // gap_cnt kept as frozen; an interrupted spawn re-picks from WAIT
            r_state <= S_WAIT;
        end else begin
            r_slot_active <= (r_slot_active & ~i_slot_done) | o_spawn;

            if (w_level_wrap) begin
                r_level_cnt <= '0;
                if (r_speed_level != 3'd7)
                    r_speed_level <= r_speed_level + 3'd1;
                r_cur_gap <= w_next_gap;
            end else if (i_frame_tick) begin
                r_level_cnt <= r_level_cnt + 16'd1;
            end

            case (r_state)
                S_WAIT: begin
                    if (r_gap_cnt == '0)
                        r_state <= S_PICK;
                    else if (i_frame_tick)
                        r_gap_cnt <= r_gap_cnt - 16'd1;
                end
                S_PICK: begin
                    r_spawn_x <= w_spawn_x;
                    if (w_any_free) begin
                        r_pick_oh <= w_free_oh;
                        r_state   <= S_SPAWN;
                    end
                end
                S_SPAWN: begin
                    r_gap_cnt <= r_cur_gap;
                    r_state   <= S_WAIT;
                end
                default: r_state <= S_WAIT;
            endcase
        end
    end

`ifdef SCHED_PERF_EN
    logic [15:0] r_spawn_count;
    logic [15:0] r_defer_count;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_spawn_count <= '0;
            r_defer_count <= '0;
        end else if (w_run) begin
            if ((|o_spawn) && r_spawn_count != 16'hFFFF)
                r_spawn_count <= r_spawn_count + 16'd1;
            if (r_state == S_PICK && !w_any_free && r_defer_count != 16'hFFFF)
                r_defer_count <= r_defer_count + 16'd1;
        end
    end

    assign o_spawn_count = r_spawn_count;
    assign o_defer_count = r_defer_count;
`endif

endmodule

// File: tb/tb_asteroid_scheduler.sv
// Directed bench for asteroid_scheduler: one instance with a short spawn gap
// for slot/halt/reset behaviour, one with a short level period for difficulty.

module tb_asteroid_scheduler;

    logic       clk;
    logic       reset;
    logic       halt;
    logic       frame_tick;
    logic       frame_tick_l;
    logic [4:0] random;
    logic [2:0] slot_done;

    logic [2:0] a_active, a_spawn, a_speed;
    logic [9:0] a_x;
    logic [2:0] l_active, l_spawn, l_speed;
    logic [9:0] l_x;
`ifdef SCHED_PERF_EN
    logic [15:0] a_scnt, a_dcnt, l_scnt, l_dcnt;
`endif

    int checks = 0;
    int failures = 0;

    asteroid_scheduler #(.INIT_GAP(4)) dut_a (
        .i_clk(clk), .i_reset(reset), .i_halt(halt), .i_frame_tick(frame_tick),
        .i_random(random), .i_slot_done(slot_done),
        .o_slot_active(a_active), .o_spawn(a_spawn), .o_spawn_x(a_x),
        .o_speed_level(a_speed)
`ifdef SCHED_PERF_EN
        , .o_spawn_count(a_scnt), .o_defer_count(a_dcnt)
`endif
    );

    asteroid_scheduler #(.INIT_GAP(30), .LEVEL_FRAMES(8), .GAP_STEP(5), .MIN_GAP(20)) dut_lvl (
        .i_clk(clk), .i_reset(reset), .i_halt(1'b0), .i_frame_tick(frame_tick_l),
        .i_random(5'd1), .i_slot_done(3'b000),
        .o_slot_active(l_active), .o_spawn(l_spawn), .o_spawn_x(l_x),
        .o_speed_level(l_speed)
`ifdef SCHED_PERF_EN
        , .o_spawn_count(l_scnt), .o_defer_count(l_dcnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic frames(input int n);
        for (int k = 0; k < n; k++) begin
            frame_tick = 1'b1;
            step();
        end
        frame_tick = 1'b0;
    endtask

    task automatic frames_l(input int n);
        for (int k = 0; k < n; k++) begin
            frame_tick_l = 1'b1;
            step();
        end
        frame_tick_l = 1'b0;
    endtask

    initial begin
        reset = 1'b1; halt = 1'b0; frame_tick = 1'b0; frame_tick_l = 1'b0;
        random = 5'd5; slot_done = 3'b000;
        step(); step();
        reset = 1'b0;
        step();

        chk("rst_active", a_active, 0);
        chk("rst_spawn", a_spawn, 0);
        chk("rst_x", a_x, 0);
        chk("rst_speed", a_speed, 0);
        chk("rst_gap", dut_a.r_gap_cnt, 4);

        // first spawn: 4 ticks, pulse two cycles later
        frames(4);
        step();
        chk("s0_early", a_spawn, 3'b000);
        step();
        chk("s0_spawn", a_spawn, 3'b001);
        chk("s0_x", a_x, 100);
        step();
        chk("s0_active", a_active, 3'b001);
        chk("s0_spawn_off", a_spawn, 3'b000);
        chk("s0_gap", dut_a.r_gap_cnt, 4);

        random = 5'd31;
        frames(4); step(); step();
        chk("s1_spawn", a_spawn, 3'b010);
        chk("s1_x", a_x, 620);
        step();
        random = 5'd7;
        frames(4); step(); step();
        chk("s2_spawn", a_spawn, 3'b100);
        chk("s2_x", a_x, 140);
        step();
        chk("full_active", a_active, 3'b111);

        // all busy: spawn deferred in PICK
        frames(4); step(); step(); step();
        chk("defer_state", dut_a.r_state, 1);
        chk("defer_spawn", a_spawn, 3'b000);
        random = 5'd3;
        slot_done = 3'b010;
        step();
        slot_done = 3'b000;
        chk("free_active", a_active, 3'b101);
        chk("free_no_spawn", a_spawn, 3'b000);
        step();
        chk("free_spawn", a_spawn, 3'b010);
        chk("free_x", a_x, 60);
        step();
        chk("refill_active", a_active, 3'b111);

        // two slots freed together, then halt mid-WAIT with gap 2
        slot_done = 3'b101;
        step();
        slot_done = 3'b000;
        chk("multi_done", a_active, 3'b010);
        frames(2);
        chk("pre_halt_gap", dut_a.r_gap_cnt, 2);
        halt = 1'b1;
        step();
        for (int k = 0; k < 100; k++) begin
            frame_tick = 1'b1;
            slot_done = (k == 50) ? 3'b010 : 3'b000;
            step();
            if (a_spawn != 3'b000) chk("halt_spawn", a_spawn, 3'b000);
        end
        frame_tick = 1'b0; slot_done = 3'b000;
        chk("halt_gap", dut_a.r_gap_cnt, 2);
        chk("halt_active", a_active, 3'b010);
        chk("halt_state", dut_a.r_state, 3);
        halt = 1'b0;
        step();
        frames(2);
        chk("unhalt_nospawn", a_spawn, 3'b000);
        step(); step();
        chk("unhalt_spawn", a_spawn, 3'b001);
        step();
        chk("unhalt_active", a_active, 3'b011);

        // halt arriving in the SPAWN cycle
        frames(4); step(); step();
        chk("hs_spawn_pre", a_spawn, 3'b100);
        halt = 1'b1;
        #1;
        chk("hs_gated", a_spawn, 3'b000);
        step();
        chk("hs_active", a_active, 3'b011);
        chk("hs_gap", dut_a.r_gap_cnt, 0);
        step();
        halt = 1'b0;
        step();
        chk("hs_wait", a_spawn, 3'b000);
        step();
        chk("hs_pick", a_spawn, 3'b000);
        step();
        chk("hs_respawn", a_spawn, 3'b100);
        step();
        chk("hs_active2", a_active, 3'b111);

        // difficulty on the short-level instance
        frames_l(7);
        chk("lvl_7", l_speed, 0);
        frames_l(1);
        chk("lvl_8", l_speed, 1);
        chk("gap_8", dut_lvl.r_cur_gap, 25);
        frames_l(16);
        chk("lvl_24", l_speed, 3);
        chk("gap_24", dut_lvl.r_cur_gap, 20);
        chk("run_gap_24", dut_lvl.r_gap_cnt, 6);
        frames_l(56);
        chk("lvl_80", l_speed, 7);
        frames_l(16);
        chk("lvl_96", l_speed, 7);

        // asynchronous reset while full and levelled up
        frames(4); step(); step();
        chk("pre_rst_state", dut_a.r_state, 1);
        reset = 1'b1;
        #1;
        chk("arst_active", a_active, 0);
        chk("arst_spawn", a_spawn, 0);
        chk("arst_x", a_x, 0);
        chk("arst_speed", l_speed, 0);
        chk("arst_gap", dut_a.r_gap_cnt, 4);
        chk("arst_cur_gap", dut_lvl.r_cur_gap, 30);
        step();
        reset = 1'b0;
        step();
        chk("post_rst_state", dut_a.r_state, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
